// File: rtl/wb_mux_pkg.sv
// Shared constants for the Wishbone slave mux: FSM encoding,
// error data default and width helpers.
package wb_mux_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FWD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic int cnt_w(input int to_cyc);
    return $clog2(to_cyc + 1);
  endfunction

  // Index width, never below one bit so NSLV=1 still builds.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/mask address decoder, lowest index wins.
// Ports: adr_i address in; hit_o any match; idx_o winning slave.
module wb_addr_decode
  import wb_mux_pkg::*;
#(
  parameter int NSLV = 4,
  parameter logic [NSLV*32-1:0] SLV_BASE = '0,
  parameter logic [NSLV*32-1:0] SLV_MASK = '0,
  localparam int IW = idx_w(NSLV)
) (
  input  logic [31:0]   adr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // Scan high to low so the lowest matching index is left last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((adr_i & SLV_MASK[32*i +: 32]) ==
          SLV_BASE[32*i +: 32]) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_slave_mux.sv
// Wishbone classic 1-to-NSLV slave mux with registered request
// and response paths, error acks for unmapped addresses and,
// with WB_MUX_TIMEOUT_EN defined, for slaves that never ack.
// Ports: wbs_* master side; m_* broadcast/per-slave side;
// err_pulse_o one-cycle error flag; err_cnt_o saturating count.
module wb_slave_mux
  import wb_mux_pkg::*;
#(
  parameter int NSLV = 4,
  parameter int DW = 32,
  parameter logic [NSLV*32-1:0] SLV_BASE = {
    32'h3200_0000, 32'h3100_0000,
    32'h3800_0000, 32'h3000_0000},
  parameter logic [NSLV*32-1:0] SLV_MASK = {
    32'hFF00_0000, 32'hFF00_0000,
    32'hFF00_0000, 32'hFFFF_FFF0},
  parameter int TO_CYC = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEF)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [DW/8-1:0]    wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [DW-1:0]      wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [DW-1:0]      wbs_dat_o,
  output logic [NSLV-1:0]    m_cyc_o,
  output logic [NSLV-1:0]    m_stb_o,
  output logic               m_we_o,
  output logic [DW/8-1:0]    m_sel_o,
  output logic [31:0]        m_adr_o,
  output logic [DW-1:0]      m_dat_o,
  input  logic [NSLV-1:0]    m_ack_i,
  input  logic [NSLV*DW-1:0] m_dat_i,
  output logic               err_pulse_o,
  output logic [7:0]         err_cnt_o
);

  localparam int IW = idx_w(NSLV);

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            err_q, err_d;
  logic [NSLV-1:0] strb_q, strb_d;
  logic            we_q, we_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [31:0]     adr_q, adr_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic [7:0]      ecnt_q, ecnt_d;

  logic            dec_hit;
  logic [IW-1:0]   dec_idx;
  logic            ack_sel;
  logic [DW-1:0]   dat_sel;
  logic            to_hit;

  wb_addr_decode #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .adr_i (wbs_adr_i),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (idx_q == IW'(i)) begin
        ack_sel = m_ack_i[i];
        dat_sel = m_dat_i[DW*i +: DW];
      end
    end
  end

`ifdef WB_MUX_TIMEOUT_EN
  localparam int CW = cnt_w(TO_CYC);

  logic [CW-1:0] to_cnt_q, to_cnt_d;

  // Zero outside FWD, so it reads 0 in the first FWD cycle.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == S_FWD) begin
      to_cnt_d = to_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign to_hit = (state_q == S_FWD) &&
                  (to_cnt_q == CW'(TO_CYC));
`else
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC != 0);
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    strb_d  = strb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ecnt_d  = ecnt_q;
    case (state_q)
      S_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          adr_d  = wbs_adr_i;
          wdat_d = wbs_dat_i;
          if (dec_hit) begin
            idx_d   = dec_idx;
            strb_d  = NSLV'(1) << dec_idx;
            state_d = S_FWD;
          end else begin
            err_d   = 1'b1;
            rdat_d  = wbs_we_i ? '0 : ERR_DATA;
            ecnt_d  = sat_inc8(ecnt_q);
            state_d = S_RESP;
          end
        end
      end
      S_FWD: begin
        // Abort beats ack: the master no longer wants a reply.
        if (!wbs_cyc_i) begin
          strb_d  = '0;
          state_d = S_IDLE;
        end else if (ack_sel) begin
          err_d   = 1'b0;
          rdat_d  = we_q ? '0 : dat_sel;
          strb_d  = '0;
          state_d = S_RESP;
        end else if (to_hit) begin
          err_d   = 1'b1;
          rdat_d  = we_q ? '0 : ERR_DATA;
          ecnt_d  = sat_inc8(ecnt_q);
          strb_d  = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        strb_d  = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      strb_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      strb_q  <= strb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign wbs_ack_o   = (state_q == S_RESP);
  assign err_pulse_o = (state_q == S_RESP) && err_q;
  assign wbs_dat_o   = rdat_q;
  assign err_cnt_o   = ecnt_q;
  assign m_cyc_o     = strb_q;
  assign m_stb_o     = strb_q;
  assign m_we_o      = we_q;
  assign m_sel_o     = sel_q;
  assign m_adr_o     = adr_q;
  assign m_dat_o     = wdat_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Directed bench for wb_slave_mux: mapped, unmapped, overlap,
// timeout/no-timeout, abort, reset and error-count saturation.
module tb_wb_slave_mux;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, wdat;
  logic         ack;
  logic [31:0]  rdat;
  logic [3:0]   mcyc, mstb;
  logic         mwe;
  logic [3:0]   msel;
  logic [31:0]  madr, mdat;
  logic [3:0]   mack;
  logic [127:0] mdin;
  logic         epulse;
  logic [7:0]   ecnt;

  int total = 0;
  int bad = 0;
  int n_ack;

  always #5 clk = ~clk;

  wb_slave_mux #(
    .NSLV     (4),
    .DW       (32),
    .SLV_BASE ({32'h3100_0000, 32'h3000_0000,
                32'h3800_0000, 32'h3000_0000}),
    .SLV_MASK ({32'hFF00_0000, 32'hFFFF_0000,
                32'hFF00_0000, 32'hFFFF_FFF0}),
    .TO_CYC   (8),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .m_cyc_o     (mcyc),
    .m_stb_o     (mstb),
    .m_we_o      (mwe),
    .m_sel_o     (msel),
    .m_adr_o     (madr),
    .m_dat_o     (mdat),
    .m_ack_i     (mack),
    .m_dat_i     (mdin),
    .err_pulse_o (epulse),
    .err_cnt_o   (ecnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a,
                     input logic w,
                     input logic [31:0] d);
    cyc  = 1'b1;
    stb  = 1'b1;
    we   = w;
    sel  = 4'hF;
    adr  = a;
    wdat = d;
  endtask

  task automatic idle();
    cyc = 1'b0;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    idle();
    sel  = 4'h0;
    adr  = '0;
    wdat = '0;
    mack = '0;
    mdin = {32'h3333_3333, 32'h2222_2222,
            32'hCAFE_F00D, 32'h1111_0000};
    tick();
    tick();
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_stb", {28'd0, mstb}, 32'd0);
    chk("rst_adr", madr, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_ecnt", {24'd0, ecnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Write, slave 0 acks in cycle 2
    req(32'h3000_0004, 1'b1, 32'h1234_5678);
    tick();
    chk("wr_adr", madr, 32'h3000_0004);
    chk("wr_stb", {28'd0, mstb}, 32'h1);
    chk("wr_cyc", {28'd0, mcyc}, 32'h1);
    chk("wr_we", {31'd0, mwe}, 32'd1);
    chk("wr_mdat", mdat, 32'h1234_5678);
    chk("wr_sel", {28'd0, msel}, 32'hF);
    chk("wr_ack1", {31'd0, ack}, 32'd0);
    tick();
    chk("wr_ack2", {31'd0, ack}, 32'd0);
    mack = 4'b0001;
    tick();
    mack = 4'b0000;
    chk("wr_ack3", {31'd0, ack}, 32'd1);
    chk("wr_rdat", rdat, 32'd0);
    chk("wr_stb_off", {28'd0, mstb}, 32'd0);
    chk("wr_ecnt", {24'd0, ecnt}, 32'd0);
    chk("wr_epulse", {31'd0, epulse}, 32'd0);
    idle();
    tick();
    chk("wr_ack4", {31'd0, ack}, 32'd0);

    // Read slave 1, acks in first FWD cycle
    req(32'h3800_0010, 1'b0, 32'h0);
    tick();
    chk("rd_stb", {28'd0, mstb}, 32'h2);
    chk("rd_we", {31'd0, mwe}, 32'd0);
    mack = 4'b0010;
    tick();
    mack = 4'b0000;
    chk("rd_ack", {31'd0, ack}, 32'd1);
    chk("rd_dat", rdat, 32'hCAFE_F00D);
    idle();
    tick();
    chk("rd_ack_off", {31'd0, ack}, 32'd0);
    chk("rd_dat_hold", rdat, 32'hCAFE_F00D);

    // Unmapped read
    req(32'h2000_0000, 1'b0, 32'h0);
    tick();
    chk("um_ack", {31'd0, ack}, 32'd1);
    chk("um_dat", rdat, 32'hDEAD_BEEF);
    chk("um_epulse", {31'd0, epulse}, 32'd1);
    chk("um_ecnt", {24'd0, ecnt}, 32'd1);
    chk("um_stb", {28'd0, mstb}, 32'd0);
    idle();
    tick();
    chk("um_ack_off", {31'd0, ack}, 32'd0);
    chk("um_ep_off", {31'd0, epulse}, 32'd0);

    // Overlap: slave 0 wins, slave 2 ack ignored
    mack = 4'b0100;
    req(32'h3000_0004, 1'b0, 32'h0);
    tick();
    chk("ov_stb", {28'd0, mstb}, 32'h1);
    tick();
    chk("ov_ign_ack", {31'd0, ack}, 32'd0);
    chk("ov_stb2", {28'd0, mstb}, 32'h1);
    mack = 4'b0101;
    tick();
    mack = 4'b0000;
    chk("ov_ack", {31'd0, ack}, 32'd1);
    chk("ov_dat", rdat, 32'h1111_0000);
    chk("ov_ep", {31'd0, epulse}, 32'd0);
    idle();
    tick();

    // Slave 3 never acks
    req(32'h3100_0000, 1'b0, 32'h0);
`ifdef WB_MUX_TIMEOUT_EN
    n_ack = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (ack) n_ack++;
    end
    chk("to_early", n_ack, 32'd0);
    chk("to_stb", {28'd0, mstb}, 32'h8);
    tick();
    chk("to_ack", {31'd0, ack}, 32'd1);
    chk("to_dat", rdat, 32'hDEAD_BEEF);
    chk("to_ep", {31'd0, epulse}, 32'd1);
    chk("to_ecnt", {24'd0, ecnt}, 32'd2);
    chk("to_stb_off", {28'd0, mstb}, 32'd0);
    idle();
    tick();
`else
    n_ack = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (ack) n_ack++;
    end
    chk("nto_acks", n_ack, 32'd0);
    chk("nto_stb", {28'd0, mstb}, 32'h8);
    chk("nto_ecnt", {24'd0, ecnt}, 32'd1);
    idle();
    tick();
    chk("nto_abort", {28'd0, mstb}, 32'd0);
`endif

    // Abort by dropping cyc in FWD
    req(32'h3000_0004, 1'b0, 32'h0);
    tick();
    chk("ab_stb", {28'd0, mstb}, 32'h1);
    idle();
    tick();
    chk("ab_stb_off", {28'd0, mstb}, 32'd0);
    chk("ab_ack", {31'd0, ack}, 32'd0);
    tick();
    chk("ab_ack2", {31'd0, ack}, 32'd0);

    // Reset pulse in FWD
    req(32'h3800_0000, 1'b0, 32'h0);
    tick();
    chk("rf_stb", {28'd0, mstb}, 32'h2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    chk("rf_stb_off", {28'd0, mstb}, 32'd0);
    chk("rf_ack", {31'd0, ack}, 32'd0);
    chk("rf_ecnt", {24'd0, ecnt}, 32'd0);
    chk("rf_adr", madr, 32'd0);
    tick();
    chk("rf_ack2", {31'd0, ack}, 32'd0);

    // 300 unmapped accesses: counter saturates
    n_ack = 0;
    for (int k = 1; k <= 300; k++) begin
      req(32'h2000_0000, 1'b0, 32'h0);
      tick();
      if (ack && epulse) n_ack++;
      idle();
      tick();
      if (k == 254) chk("sat_254", {24'd0, ecnt}, 32'd254);
    end
    chk("sat_acks", n_ack, 32'd300);
    chk("sat_255", {24'd0, ecnt}, 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
